// File: rtl/uart_mmio_ctrl.sv
// MMIO responder for the 0x8000_00xx region: UART RX buffer / TX holding register,
// cycle and retired-instruction counters. Define MMIO_RX_FIFO_EN for a multi-entry RX FIFO.
module uart_mmio_ctrl #(
    parameter int unsigned RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmio_addr,
    input  logic        mmio_re,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retire,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready
);

    localparam logic [29:0] A_CTRL = 30'h2000_0000;
    localparam logic [29:0] A_RX   = 30'h2000_0001;
    localparam logic [29:0] A_TX   = 30'h2000_0002;
    localparam logic [29:0] A_CYC  = 30'h2000_0004;
    localparam logic [29:0] A_INST = 30'h2000_0005;
    localparam logic [29:0] A_CRST = 30'h2000_0006;

    logic [29:0] word_addr;
    logic        wr_any;
    assign word_addr = mmio_addr[31:2];
    assign wr_any    = |mmio_we;

    logic       rx_nonempty;
    logic       rx_full;
    logic [7:0] rx_head;
    logic       rx_push;
    logic       rx_pop;

    assign uart_rx_data_out_ready = !rx_full;
    assign rx_push = uart_rx_data_out_valid && !rx_full;
    assign rx_pop  = mmio_re && (word_addr == A_RX) && rx_nonempty;

`ifdef MMIO_RX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_FIFO_DEPTH);

    logic [7:0]       rx_mem_q [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wptr_q, rx_wptr_d;
    logic [PTR_W-1:0] rx_rptr_q, rx_rptr_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;

    assign rx_full     = (rx_cnt_q == FULL_CNT);
    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_head     = rx_mem_q[rx_rptr_q];

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push) rx_wptr_d = rx_wptr_q + PTR_W'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_W'(1);
        // Simultaneous push and pop leave occupancy unchanged.
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_W'(1);
        else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= uart_rx_data_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end
`else
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_full_q, rx_full_d;

    assign rx_full     = rx_full_q;
    assign rx_nonempty = rx_full_q;
    assign rx_head     = rx_data_q;

    // Push is only possible when empty and pop only when full, so they never coincide.
    always_comb begin
        rx_data_d = rx_data_q;
        rx_full_d = rx_full_q;
        if (rx_push) begin
            rx_data_d = uart_rx_data_out;
            rx_full_d = 1'b1;
        end else if (rx_pop) begin
            rx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q <= '0;
            rx_full_q <= 1'b0;
        end else begin
            rx_data_q <= rx_data_d;
            rx_full_q <= rx_full_d;
        end
    end

    logic unused_depth;
    assign unused_depth = (RX_FIFO_DEPTH == 0);
`endif

    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       tx_load;

    // A store to a full holding register is dropped even if it drains this cycle.
    assign tx_load = mmio_we[0] && (word_addr == A_TX) && !tx_valid_q;

    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (tx_load) begin
            tx_data_d  = mmio_wdata[7:0];
            tx_valid_d = 1'b1;
        end else if (tx_valid_q && uart_tx_data_in_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    assign uart_tx_data_in       = tx_data_q;
    assign uart_tx_data_in_valid = tx_valid_q;

    logic [31:0] cyc_q, cyc_d;
    logic [31:0] inst_q, inst_d;
    logic        cnt_clr;

    assign cnt_clr = wr_any && (word_addr == A_CRST);

    always_comb begin
        cyc_d  = cyc_q + 32'd1;
        inst_d = inst_q + {31'd0, inst_retire};
        if (cnt_clr) begin
            cyc_d  = '0;
            inst_d = '0;
        end
    end

    logic [31:0] rdata_q, rdata_d;

    // Read data reflects state before this cycle's updates.
    always_comb begin
        rdata_d = rdata_q;
        if (mmio_re) begin
            case (word_addr)
                A_CTRL:  rdata_d = {30'd0, rx_nonempty, !tx_valid_q};
                A_RX:    rdata_d = rx_nonempty ? {24'd0, rx_head} : 32'd0;
                A_CYC:   rdata_d = cyc_q;
                A_INST:  rdata_d = inst_q;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    assign mmio_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cyc_q      <= '0;
            inst_q     <= '0;
            rdata_q    <= '0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
            rdata_q    <= rdata_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:8]};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed self-checking bench for uart_mmio_ctrl (default build or MMIO_RX_FIFO_EN).
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mmio_addr;
    logic        mmio_re;
    logic [3:0]  mmio_we;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        inst_retire;
    logic [7:0]  uart_rx_data_out;
    logic        uart_rx_data_out_valid;
    logic        uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready;

    int n_checks = 0;
    int n_pass   = 0;

    uart_mmio_ctrl #(.RX_FIFO_DEPTH(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .mmio_addr              (mmio_addr),
        .mmio_re                (mmio_re),
        .mmio_we                (mmio_we),
        .mmio_wdata             (mmio_wdata),
        .mmio_rdata             (mmio_rdata),
        .inst_retire            (inst_retire),
        .uart_rx_data_out       (uart_rx_data_out),
        .uart_rx_data_out_valid (uart_rx_data_out_valid),
        .uart_rx_data_out_ready (uart_rx_data_out_ready),
        .uart_tx_data_in        (uart_tx_data_in),
        .uart_tx_data_in_valid  (uart_tx_data_in_valid),
        .uart_tx_data_in_ready  (uart_tx_data_in_ready)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] CTRL = 32'h8000_0000;
    localparam logic [31:0] RXD  = 32'h8000_0004;
    localparam logic [31:0] TXD  = 32'h8000_0008;
    localparam logic [31:0] CYC  = 32'h8000_0010;
    localparam logic [31:0] INST = 32'h8000_0014;
    localparam logic [31:0] CRST = 32'h8000_0018;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
        mmio_addr = a;
        mmio_re   = 1'b1;
        tick();
        mmio_re   = 1'b0;
        d = mmio_rdata;
    endtask

    task automatic mmio_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        mmio_addr  = a;
        mmio_we    = we;
        mmio_wdata = wd;
        tick();
        mmio_we    = 4'h0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        uart_rx_data_out       = b;
        uart_rx_data_out_valid = 1'b1;
        tick();
        uart_rx_data_out_valid = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        rst = 1'b1;
        mmio_addr = '0; mmio_re = 1'b0; mmio_we = '0; mmio_wdata = '0;
        inst_retire = 1'b0; uart_rx_data_out = '0; uart_rx_data_out_valid = 1'b0;
        uart_tx_data_in_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("rst_rdata", mmio_rdata, 32'h0);
        check("rst_rx_ready", {31'd0, uart_rx_data_out_ready}, 32'h1);
        check("rst_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h0);
        check("rst_tx_data", {24'd0, uart_tx_data_in}, 32'h0);
        mmio_read(CTRL, rd); check("rst_ctrl", rd, 32'h1);
        tick();
        check("rdata_hold", mmio_rdata, 32'h1);
        mmio_read(32'h8000_0020, rd); check("unmapped_rd", rd, 32'h0);

`ifdef MMIO_RX_FIFO_EN
        rx_send(8'h41); rx_send(8'h42); rx_send(8'h43);
        mmio_read(CTRL, rd); check("rx3_ctrl", rd, 32'h3);
        mmio_read(RXD, rd); check("rx3_b0", rd, 32'h41);
        mmio_read(RXD, rd); check("rx3_b1", rd, 32'h42);
        mmio_read(RXD, rd); check("rx3_b2", rd, 32'h43);
        mmio_read(RXD, rd); check("rx3_empty", rd, 32'h0);
        mmio_read(CTRL, rd); check("rx3_ctrl_end", rd, 32'h1);

        for (int i = 0; i < 8; i++) rx_send(8'h10 + 8'(i));
        check("fifo_full_ready", {31'd0, uart_rx_data_out_ready}, 32'h0);
        rx_send(8'h18);
        // Pop while full with a byte offered: pop happens, push is blocked.
        uart_rx_data_out = 8'h19; uart_rx_data_out_valid = 1'b1;
        mmio_read(RXD, rd);
        uart_rx_data_out_valid = 1'b0;
        check("fifo_pop_full", rd, 32'h10);
        check("fifo_after_pop_ready", {31'd0, uart_rx_data_out_ready}, 32'h1);
        rx_send(8'h1A);
        check("fifo_refull_ready", {31'd0, uart_rx_data_out_ready}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            mmio_read(RXD, rd); check("fifo_drain", rd, 32'h11 + i);
        end
        mmio_read(RXD, rd); check("fifo_last", rd, 32'h1A);
        mmio_read(RXD, rd); check("fifo_empty", rd, 32'h0);
`else
        rx_send(8'h41);
        check("rx1_ready_full", {31'd0, uart_rx_data_out_ready}, 32'h0);
        rx_send(8'h42);
        mmio_read(CTRL, rd); check("rx1_ctrl", rd, 32'h3);
        mmio_read(RXD, rd); check("rx1_b0", rd, 32'h41);
        mmio_read(RXD, rd); check("rx1_drop", rd, 32'h0);
        rx_send(8'h42);
        mmio_read(RXD, rd); check("rx1_b1", rd, 32'h42);
        rx_send(8'h43);
        // Pop while full with a byte offered: push is blocked that cycle.
        uart_rx_data_out = 8'h44; uart_rx_data_out_valid = 1'b1;
        mmio_read(RXD, rd);
        uart_rx_data_out_valid = 1'b0;
        check("rx1_b2", rd, 32'h43);
        check("rx1_ready_after", {31'd0, uart_rx_data_out_ready}, 32'h1);
        mmio_read(RXD, rd); check("rx1_empty", rd, 32'h0);
        mmio_read(CTRL, rd); check("rx1_ctrl_end", rd, 32'h1);
`endif

        // TX path with the transmitter stalled.
        mmio_write(TXD, 4'h2, 32'h33);
        check("tx_we0_off", {31'd0, uart_tx_data_in_valid}, 32'h0);
        mmio_write(TXD, 4'h1, 32'h55);
        check("tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h1);
        check("tx_data", {24'd0, uart_tx_data_in}, 32'h55);
        mmio_write(TXD, 4'hF, 32'hAA);
        check("tx_drop", {24'd0, uart_tx_data_in}, 32'h55);
        mmio_read(CTRL, rd); check("tx_busy_ctrl", rd, 32'h0);
        uart_tx_data_in_ready = 1'b1; tick(); uart_tx_data_in_ready = 1'b0;
        check("tx_drained", {31'd0, uart_tx_data_in_valid}, 32'h0);
        mmio_read(CTRL, rd); check("tx_idle_ctrl", rd, 32'h1);

        // Read and write together: read reports state before the write.
        mmio_addr = CTRL; mmio_re = 1'b1; mmio_we = 4'h0;
        tick(); mmio_re = 1'b0;
        mmio_addr = TXD; mmio_we = 4'h1; mmio_wdata = 32'h66; mmio_re = 1'b1;
        tick(); mmio_re = 1'b0; mmio_we = 4'h0;
        check("rw_same_cycle", mmio_rdata, 32'h0);
        check("rw_tx_data", {24'd0, uart_tx_data_in}, 32'h66);
        // Store while draining is still dropped.
        uart_tx_data_in_ready = 1'b1;
        mmio_write(TXD, 4'h1, 32'hBB);
        uart_tx_data_in_ready = 1'b0;
        check("tx_drop_on_drain", {31'd0, uart_tx_data_in_valid}, 32'h0);

        // Counters.
        mmio_write(CRST, 4'h4, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i < 40);
            tick();
        end
        inst_retire = 1'b0;
        mmio_read(CYC, rd);  check("cyc_100", rd, 32'd100);
        mmio_read(INST, rd); check("inst_40", rd, 32'd40);
        mmio_read(CYC, rd);  check("cyc_102", rd, 32'd102);
        inst_retire = 1'b1;
        mmio_write(CRST, 4'h1, 32'h0);
        mmio_read(CYC, rd);  check("cyc_clr", rd, 32'd0);
        mmio_read(INST, rd); check("inst_clr", rd, 32'd1);
        inst_retire = 1'b0;

        // Reset with RX bytes buffered and a TX byte pending.
        rx_send(8'h61); rx_send(8'h62); rx_send(8'h63);
        mmio_write(TXD, 4'h1, 32'h77);
        check("pre_rst_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h0);
        check("mid_rst_rx_ready", {31'd0, uart_rx_data_out_ready}, 32'h1);
        mmio_read(CTRL, rd); check("mid_rst_ctrl", rd, 32'h1);
        mmio_read(RXD, rd);  check("mid_rst_rx", rd, 32'h0);
        mmio_read(CYC, rd);  check("mid_rst_cyc", rd, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
